// File: rtl/centroid_tracker.sv
// Purpose  : pixel-mean centroid of colour-thresholded pixels over each raster frame.
// Latency  : o_end_frame at T+1 after the last pixel; centroid update at T+29 (T+1 when below MIN_PIXELS).
// Backpress: none; one pixel is taken on every i_data_valid cycle, and gaps in i_data_valid only stall the position counters.
//
// Ports:
//   i_clk, i_rstn          clock, synchronous active-low reset
//   i_data_valid, i_data   pixel strobe and {R,G,B} nibbles
//   i_sof                  start of frame, qualified by i_data_valid; forces position (0,0)
//   o_centroid_x/y         truncated mean column/row of matching pixels
//   o_detected             last completed frame had at least MIN_PIXELS matches
//   o_centroid_valid       one-cycle pulse when the centroid outputs are updated
//   o_end_frame            one-cycle pulse on the cycle after the last pixel of a frame
//   o_match_count          match count of the last completed frame
//   o_overrun              sticky; a frame ended while the divider was still busy
module centroid_tracker #(
    parameter int         H_ACTIVE   = 640,
    parameter int         V_ACTIVE   = 480,
    parameter logic [3:0] R_MIN      = 4'hC,
    parameter logic [3:0] G_MAX      = 4'h4,
    parameter logic [3:0] B_MAX      = 4'h4,
    parameter int         MIN_PIXELS = 16
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_data_valid,
    input  logic [11:0] i_data,
    input  logic        i_sof,
    output logic [9:0]  o_centroid_x,
    output logic [8:0]  o_centroid_y,
    output logic        o_detected,
    output logic        o_centroid_valid,
    output logic        o_end_frame,
    output logic [18:0] o_match_count,
    output logic        o_overrun
);

    localparam logic [1:0]  S_IDLE   = 2'd0;
    localparam logic [1:0]  S_DIV    = 2'd1;
    localparam logic [1:0]  S_DONE   = 2'd2;

    localparam logic [9:0]  X_LAST   = 10'(H_ACTIVE - 1);
    localparam logic [8:0]  Y_LAST   = 9'(V_ACTIVE - 1);
    localparam logic [18:0] MIN_CNT  = 19'(MIN_PIXELS);
    localparam logic [4:0]  DIV_LAST = 5'd27;

    // Raster position and running accumulators of the frame in progress.
    logic [9:0]  x_cnt_q, x_cnt_d;
    logic [8:0]  y_cnt_q, y_cnt_d;
    logic [27:0] sum_x_q, sum_x_d;
    logic [27:0] sum_y_q, sum_y_d;
    logic [18:0] cnt_q,   cnt_d;

    // Divider state. The dividend registers shift left one bit per iteration and
    // take the new quotient bit in at the bottom, so after 28 iterations they
    // hold the quotients.
    logic [1:0]  state_q,   state_d;
    logic [4:0]  iter_q,    iter_d;
    logic [27:0] div_x_q,   div_x_d;
    logic [27:0] div_y_q,   div_y_d;
    logic [18:0] rem_x_q,   rem_x_d;
    logic [18:0] rem_y_q,   rem_y_d;
    logic [18:0] divisor_q, divisor_d;

    // Output registers.
    logic [9:0]  centroid_x_q,     centroid_x_d;
    logic [8:0]  centroid_y_q,     centroid_y_d;
    logic        detected_q,       detected_d;
    logic        centroid_valid_q, centroid_valid_d;
    logic        end_frame_q,      end_frame_d;
    logic [18:0] match_count_q,    match_count_d;
    logic        overrun_q,        overrun_d;

    // Pixel-path combinational terms.
    logic        pix_match;
    logic [9:0]  cur_x;
    logic [8:0]  cur_y;
    logic [27:0] acc_x;
    logic [27:0] acc_y;
    logic [18:0] acc_cnt;
    logic        frame_end;

    // One restoring-divide iteration for each of the two divides.
    logic [19:0] trial_x,  trial_y;
    logic        ge_x,     ge_y;
    logic [18:0] rem_x_n,  rem_y_n;
    logic [27:0] quot_x_n, quot_y_n;

    always_comb begin
        pix_match = (i_data[11:8] >= R_MIN) && (i_data[7:4] <= G_MAX) && (i_data[3:0] <= B_MAX);

        // A start-of-frame pixel sits at (0,0) and starts from empty accumulators,
        // which throws away whatever partial frame preceded it.
        cur_x   = i_sof ? 10'd0 : x_cnt_q;
        cur_y   = i_sof ? 9'd0  : y_cnt_q;
        acc_x   = (i_sof ? 28'd0 : sum_x_q) + (pix_match ? {18'd0, cur_x} : 28'd0);
        acc_y   = (i_sof ? 28'd0 : sum_y_q) + (pix_match ? {19'd0, cur_y} : 28'd0);
        acc_cnt = (i_sof ? 19'd0 : cnt_q)   + {18'd0, pix_match};

        frame_end = i_data_valid && (cur_x == X_LAST) && (cur_y == Y_LAST);
    end

    always_comb begin
        trial_x  = {rem_x_q, div_x_q[27]};
        ge_x     = trial_x >= {1'b0, divisor_q};
        rem_x_n  = ge_x ? 19'(trial_x - {1'b0, divisor_q}) : trial_x[18:0];
        quot_x_n = {div_x_q[26:0], ge_x};

        trial_y  = {rem_y_q, div_y_q[27]};
        ge_y     = trial_y >= {1'b0, divisor_q};
        rem_y_n  = ge_y ? 19'(trial_y - {1'b0, divisor_q}) : trial_y[18:0];
        quot_y_n = {div_y_q[26:0], ge_y};
    end

    // Position counters and accumulators.
    always_comb begin
        x_cnt_d = x_cnt_q;
        y_cnt_d = y_cnt_q;
        sum_x_d = sum_x_q;
        sum_y_d = sum_y_q;
        cnt_d   = cnt_q;

        if (i_data_valid) begin
            if (frame_end) begin
                // The final pixel is folded into the snapshot taken by the FSM;
                // the accumulators restart empty for the next frame.
                x_cnt_d = 10'd0;
                y_cnt_d = 9'd0;
                sum_x_d = 28'd0;
                sum_y_d = 28'd0;
                cnt_d   = 19'd0;
            end else begin
                sum_x_d = acc_x;
                sum_y_d = acc_y;
                cnt_d   = acc_cnt;
                if (cur_x == X_LAST) begin
                    x_cnt_d = 10'd0;
                    y_cnt_d = cur_y + 9'd1;
                end else begin
                    x_cnt_d = cur_x + 10'd1;
                    y_cnt_d = cur_y;
                end
            end
        end
    end

    // Divider FSM and output loading.
    always_comb begin
        state_d          = state_q;
        iter_d           = iter_q;
        div_x_d          = div_x_q;
        div_y_d          = div_y_q;
        rem_x_d          = rem_x_q;
        rem_y_d          = rem_y_q;
        divisor_d        = divisor_q;
        centroid_x_d     = centroid_x_q;
        centroid_y_d     = centroid_y_q;
        detected_d       = detected_q;
        match_count_d    = match_count_q;
        overrun_d        = overrun_q;
        centroid_valid_d = 1'b0;
        end_frame_d      = frame_end;

        // A frame that ends while a divide is in flight loses its snapshot.
        if (frame_end && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (frame_end) begin
                    if (acc_cnt >= MIN_CNT) begin
                        div_x_d   = acc_x;
                        div_y_d   = acc_y;
                        divisor_d = acc_cnt;
                        rem_x_d   = 19'd0;
                        rem_y_d   = 19'd0;
                        iter_d    = 5'd0;
                        state_d   = S_DIV;
                    end else begin
                        // Too few matches: keep the old centroid, report no detection.
                        detected_d       = 1'b0;
                        match_count_d    = acc_cnt;
                        centroid_valid_d = 1'b1;
                        state_d          = S_DONE;
                    end
                end
            end

            S_DIV: begin
                div_x_d = quot_x_n;
                div_y_d = quot_y_n;
                rem_x_d = rem_x_n;
                rem_y_d = rem_y_n;
                iter_d  = iter_q + 5'd1;
                if (iter_q == DIV_LAST) begin
                    // The mean never exceeds the largest coordinate, so the low
                    // quotient bits carry the whole result.
                    centroid_x_d     = quot_x_n[9:0];
                    centroid_y_d     = quot_y_n[8:0];
                    detected_d       = 1'b1;
                    match_count_d    = divisor_q;
                    centroid_valid_d = 1'b1;
                    state_d          = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            x_cnt_q          <= 10'd0;
            y_cnt_q          <= 9'd0;
            sum_x_q          <= 28'd0;
            sum_y_q          <= 28'd0;
            cnt_q            <= 19'd0;
            state_q          <= S_IDLE;
            iter_q           <= 5'd0;
            div_x_q          <= 28'd0;
            div_y_q          <= 28'd0;
            rem_x_q          <= 19'd0;
            rem_y_q          <= 19'd0;
            divisor_q        <= 19'd0;
            centroid_x_q     <= 10'd0;
            centroid_y_q     <= 9'd0;
            detected_q       <= 1'b0;
            centroid_valid_q <= 1'b0;
            end_frame_q      <= 1'b0;
            match_count_q    <= 19'd0;
            overrun_q        <= 1'b0;
        end else begin
            x_cnt_q          <= x_cnt_d;
            y_cnt_q          <= y_cnt_d;
            sum_x_q          <= sum_x_d;
            sum_y_q          <= sum_y_d;
            cnt_q            <= cnt_d;
            state_q          <= state_d;
            iter_q           <= iter_d;
            div_x_q          <= div_x_d;
            div_y_q          <= div_y_d;
            rem_x_q          <= rem_x_d;
            rem_y_q          <= rem_y_d;
            divisor_q        <= divisor_d;
            centroid_x_q     <= centroid_x_d;
            centroid_y_q     <= centroid_y_d;
            detected_q       <= detected_d;
            centroid_valid_q <= centroid_valid_d;
            end_frame_q      <= end_frame_d;
            match_count_q    <= match_count_d;
            overrun_q        <= overrun_d;
        end
    end

    assign o_centroid_x     = centroid_x_q;
    assign o_centroid_y     = centroid_y_q;
    assign o_detected       = detected_q;
    assign o_centroid_valid = centroid_valid_q;
    assign o_end_frame      = end_frame_q;
    assign o_match_count    = match_count_q;
    assign o_overrun        = overrun_q;

endmodule

// File: tb/tb_centroid_tracker.sv
// Purpose  : directed bench for centroid_tracker with hand-computed results.
// Latency  : checks the valid pulse at T+29 (T+1 for low counts) and end_frame at T+1.
// Backpress: exercises random i_data_valid gaps; the DUT has no backpressure.
//
// The frame is shrunk to 112x56 so that several frames fit in a short run; the
// 4x4 block at x 100..103, y 50..53 still lies inside it.
module tb_centroid_tracker;

    localparam int H = 112;
    localparam int V = 56;

    logic        i_clk = 1'b0;
    logic        i_rstn = 1'b0;
    logic        i_data_valid = 1'b0;
    logic [11:0] i_data = 12'h000;
    logic        i_sof = 1'b0;
    logic [9:0]  o_centroid_x;
    logic [8:0]  o_centroid_y;
    logic        o_detected;
    logic        o_centroid_valid;
    logic        o_end_frame;
    logic [18:0] o_match_count;
    logic        o_overrun;

    centroid_tracker #(
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .R_MIN      (4'hC),
        .G_MAX      (4'h4),
        .B_MAX      (4'h4),
        .MIN_PIXELS (16)
    ) dut (
        .i_clk            (i_clk),
        .i_rstn           (i_rstn),
        .i_data_valid     (i_data_valid),
        .i_data           (i_data),
        .i_sof            (i_sof),
        .o_centroid_x     (o_centroid_x),
        .o_centroid_y     (o_centroid_y),
        .o_detected       (o_detected),
        .o_centroid_valid (o_centroid_valid),
        .o_end_frame      (o_end_frame),
        .o_match_count    (o_match_count),
        .o_overrun        (o_overrun)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Pulse monitor, sampled on the falling edge.
    int          n_valid;
    int          valid_cyc;
    int          n_end;
    int          end_cyc;
    int          last_cyc;
    logic [9:0]  cap_x;
    logic [8:0]  cap_y;
    logic        cap_det;
    logic [18:0] cap_cnt;

    always @(negedge i_clk) begin
        if (o_centroid_valid) begin
            n_valid   = n_valid + 1;
            valid_cyc = cyc;
            cap_x     = o_centroid_x;
            cap_y     = o_centroid_y;
            cap_det   = o_detected;
            cap_cnt   = o_match_count;
        end
        if (o_end_frame) begin
            n_end   = n_end + 1;
            end_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        n_valid   = 0;
        n_end     = 0;
        valid_cyc = -1;
        end_cyc   = -1;
    endtask

    // mode 0: 4x4 red block; mode 1: ten boundary matches plus near misses; mode 2: all red.
    function automatic logic [11:0] pixel(input int mode, input int x, input int y);
        logic [11:0] p;
        p = 12'h000;
        case (mode)
            0: if (x >= 100 && x <= 103 && y >= 50 && y <= 53) p = 12'hF00;
            1: begin
                if (x < 10) begin
                    if (y == 10) p = 12'hC44;
                    if (y == 11) p = 12'hB44;
                    if (y == 12) p = 12'hC54;
                    if (y == 13) p = 12'hC45;
                end
            end
            default: p = 12'hF00;
        endcase
        return p;
    endfunction

    // Presents one input cycle; the inputs are held across the next rising edge.
    task automatic put(input logic v, input logic [11:0] d, input logic s);
        i_data_valid = v;
        i_data       = d;
        i_sof        = s;
        if (v) last_cyc = cyc;
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive_frame(input int mode, input bit use_sof, input bit gaps);
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                // Idle cycles carry matching data and a stray sof that must be ignored.
                if (gaps) begin
                    while ($urandom_range(0, 1) == 0) put(1'b0, 12'hF00, 1'b1);
                end
                put(1'b1, pixel(mode, x, y), use_sof && x == 0 && y == 0);
            end
        end
        i_data_valid = 1'b0;
        i_sof        = 1'b0;
        i_data       = 12'h000;
    endtask

    task automatic expect_result(input string tag, input int ex, input int ey,
                                 input int ecnt, input int edet, input int edelay);
        repeat (40) @(posedge i_clk);
        #1;
        check({tag, " valid pulses"}, n_valid, 1);
        check({tag, " valid delay"}, valid_cyc - last_cyc, edelay);
        check({tag, " end pulses"}, n_end, 1);
        check({tag, " end delay"}, end_cyc - last_cyc, 1);
        check({tag, " x"}, 32'(cap_x), ex);
        check({tag, " y"}, 32'(cap_y), ey);
        check({tag, " count"}, 32'(cap_cnt), ecnt);
        check({tag, " detected"}, 32'(cap_det), edet);
        check({tag, " x held"}, 32'(o_centroid_x), ex);
        check({tag, " y held"}, 32'(o_centroid_y), ey);
    endtask

    initial begin
        clear_mon();
        last_cyc = 0;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst x", 32'(o_centroid_x), 0);
        check("rst y", 32'(o_centroid_y), 0);
        check("rst detected", 32'(o_detected), 0);
        check("rst valid", 32'(o_centroid_valid), 0);
        check("rst end", 32'(o_end_frame), 0);
        check("rst count", 32'(o_match_count), 0);
        check("rst overrun", 32'(o_overrun), 0);
        i_rstn = 1'b1;
        @(posedge i_clk);
        #1;

        // 4x4 block: sum_x 1624, sum_y 824 over 16 -> (101,51).
        clear_mon();
        drive_frame(0, 1'b1, 1'b0);
        expect_result("block", 101, 51, 16, 1, 29);

        // Ten matches at the threshold edges: centroid held, no detection.
        clear_mon();
        drive_frame(1, 1'b0, 1'b0);
        expect_result("below", 101, 51, 10, 0, 1);

        // Every pixel matches: 348096/6272 -> 55, 172480/6272 -> 27.
        clear_mon();
        drive_frame(2, 1'b0, 1'b0);
        expect_result("full", 55, 27, H * V, 1, 29);

        // Same block with random idle cycles in between pixels.
        clear_mon();
        drive_frame(0, 1'b0, 1'b1);
        expect_result("gaps", 101, 51, 16, 1, 29);

        // All-red partial frame up to (60,30), then sof restarts with the block frame.
        clear_mon();
        for (int y = 0; y <= 30; y++) begin
            for (int x = 0; x < H; x++) begin
                if (!(y == 30 && x >= 60)) put(1'b1, 12'hF00, 1'b0);
            end
        end
        drive_frame(0, 1'b1, 1'b0);
        expect_result("sof", 101, 51, 16, 1, 29);

        // Reset at T+10 while the divider is busy.
        clear_mon();
        drive_frame(0, 1'b0, 1'b0);
        repeat (9) @(posedge i_clk);
        #1;
        check("pre-reset cycle", cyc - last_cyc, 10);
        i_rstn = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rstn = 1'b1;
        repeat (40) @(posedge i_clk);
        #1;
        check("abort valid pulses", n_valid, 0);
        check("abort x", 32'(o_centroid_x), 0);
        check("abort y", 32'(o_centroid_y), 0);
        check("abort detected", 32'(o_detected), 0);
        check("abort count", 32'(o_match_count), 0);

        clear_mon();
        drive_frame(0, 1'b0, 1'b0);
        expect_result("post reset", 101, 51, 16, 1, 29);

        check("overrun", 32'(o_overrun), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
